// File: rtl/joy_pkg.sv
// rtl/joy_pkg.sv - shared types and constants for the joystick poll scheduler
package joy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_XFER,
        ST_GAP,
        ST_DONE,
        ST_HOLD,
        ST_ERR
    } state_t;

    localparam logic [5:0] JSTK_LED_CMD = 6'b100000;
    localparam int         FRAME_W      = 40;

    typedef logic slot_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } joy_pos_t;

    function automatic logic [1:0] slot_mask(slot_t s);
        return s ? 2'b10 : 2'b01;
    endfunction

    // b0 arrives first and therefore sits in the top byte of the frame
    function automatic joy_pos_t decode_frame(logic [FRAME_W-1:0] f);
        joy_pos_t p;
        p.x   = {f[25:24], f[39:32]};
        p.y   = {f[9:8],   f[23:16]};
        p.btn = f[2:0];
        return p;
    endfunction

endpackage

// File: rtl/joy_poll_sched_poll_tick_gen.sv
// rtl/joy_poll_sched_poll_tick_gen.sv - free-running poll period counter with one-cycle tick
module poll_tick_gen #(
    parameter int POLL_DIV = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CW = $clog2(POLL_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(POLL_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/joy_poll_sched.sv
// rtl/joy_poll_sched.sv - two-slot joystick poller sharing one SPI byte engine
module joy_poll_sched
    import joy_pkg::*;
#(
    parameter int POLL_DIV  = 100000,
    parameter int NUM_BYTES = 5,
    parameter int SETUP     = 8,
    parameter int GAP       = 4,
    parameter int TIMEOUT   = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] en,
    input  logic [1:0] req,
    input  logic [1:0] led0,
    input  logic [1:0] led1,
    input  logic       BUSY,
    input  logic [7:0] Data_rx,
    output logic       getByte,
    output logic [7:0] Data_send,
    output logic [1:0] cs_n,
    output logic [9:0] x0,
    output logic [9:0] y0,
    output logic [2:0] btn0,
    output logic [9:0] x1,
    output logic [9:0] y1,
    output logic [2:0] btn1,
    output logic [1:0] frame_vld,
    output logic [1:0] err
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = 16;

    state_t             state_q;
    logic [1:0]         pending_q;
    slot_t              rr_q;
    slot_t              grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WD_W-1:0]    wd_q;
    logic [2:0]         byte_cnt_q;
    logic [FRAME_W-1:0] frame_q;

    logic       tick;
    logic [1:0] set_d;
    slot_t      grant_d;
    logic [1:0] grant_mask_d;
    logic [1:0] led_sel;
    logic       wd_expired;
    joy_pos_t   pos;

    poll_tick_gen #(
        .POLL_DIV(POLL_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(rst_n),
        .tick_o(tick)
    );

    // rr_q holds the last-served slot; with both pending the other one wins
    always_comb begin
        set_d        = req | (tick ? en : 2'b00);
        grant_d      = (pending_q == 2'b11) ? ~rr_q : pending_q[1];
        grant_mask_d = slot_mask(grant_d);
        led_sel      = grant_q ? led1 : led0;
        wd_expired   = (wd_q == WD_W'(TIMEOUT - 1));
        pos          = decode_frame(frame_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 2'b00;
            rr_q       <= 1'b1;
            grant_q    <= 1'b0;
            cnt_q      <= '0;
            wd_q       <= '0;
            byte_cnt_q <= '0;
            frame_q    <= '0;
            getByte    <= 1'b0;
            Data_send  <= 8'h00;
            cs_n       <= 2'b11;
            x0         <= '0;
            y0         <= '0;
            btn0       <= '0;
            x1         <= '0;
            y1         <= '0;
            btn1       <= '0;
            frame_vld  <= 2'b00;
            err        <= 2'b00;
        end else begin
            pending_q <= pending_q | set_d;
            frame_vld <= 2'b00;
            err       <= 2'b00;
            cnt_q     <= cnt_q + CNT_W'(1);
            wd_q      <= wd_q + WD_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (|pending_q) begin
                        // a request arriving in the grant cycle survives the clear
                        pending_q <= (pending_q & ~grant_mask_d) | set_d;
                        grant_q   <= grant_d;
                        rr_q      <= grant_d;
                        cs_n      <= ~grant_mask_d;
                        cnt_q     <= '0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CNT_W'(SETUP - 1)) begin
                        byte_cnt_q <= '0;
                        getByte    <= 1'b1;
                        Data_send  <= {JSTK_LED_CMD, led_sel};
                        wd_q       <= '0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (BUSY) begin
                        getByte <= 1'b0;
                        wd_q    <= '0;
                        state_q <= ST_XFER;
                    end else if (wd_expired) begin
                        getByte <= 1'b0;
                        cs_n    <= 2'b11;
                        state_q <= ST_ERR;
                    end
                end
                ST_XFER: begin
                    if (!BUSY) begin
                        frame_q    <= {frame_q[FRAME_W-9:0], Data_rx};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        cnt_q      <= '0;
                        if (byte_cnt_q == 3'(NUM_BYTES - 1)) begin
                            cs_n    <= 2'b11;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end else if (wd_expired) begin
                        cs_n    <= 2'b11;
                        state_q <= ST_ERR;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        getByte   <= 1'b1;
                        Data_send <= 8'h00;
                        wd_q      <= '0;
                        state_q   <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    if (grant_q) begin
                        x1   <= pos.x;
                        y1   <= pos.y;
                        btn1 <= pos.btn;
                    end else begin
                        x0   <= pos.x;
                        y0   <= pos.y;
                        btn0 <= pos.btn;
                    end
                    frame_vld <= slot_mask(grant_q);
                    cnt_q     <= '0;
                    state_q   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(SETUP - 1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    err     <= slot_mask(grant_q);
                    cnt_q   <= '0;
                    state_q <= ST_HOLD;
                end
                default: begin
                    cs_n    <= 2'b11;
                    getByte <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_poll_sched.sv
// tb/tb_joy_poll_sched.sv - scoreboard bench for joy_poll_sched with a behavioural byte engine
module tb_joy_poll_sched;

    localparam int SETUP    = 8;
    localparam int TIMEOUT  = 100;
    localparam int POLL_DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] en = 2'b00;
    logic [1:0] req = 2'b00;
    logic [1:0] led0 = 2'b11;
    logic [1:0] led1 = 2'b01;
    logic       BUSY = 1'b0;
    logic [7:0] Data_rx = 8'h00;
    logic       getByte;
    logic [7:0] Data_send;
    logic [1:0] cs_n;
    logic [9:0] x0, y0, x1, y1;
    logic [2:0] btn0, btn1;
    logic [1:0] frame_vld;
    logic [1:0] err;

    always #5 clk = ~clk;

    joy_poll_sched #(
        .POLL_DIV (POLL_DIV),
        .NUM_BYTES(5),
        .SETUP    (SETUP),
        .GAP      (4),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .led0     (led0),
        .led1     (led1),
        .BUSY     (BUSY),
        .Data_rx  (Data_rx),
        .getByte  (getByte),
        .Data_send(Data_send),
        .cs_n     (cs_n),
        .x0       (x0),
        .y0       (y0),
        .btn0     (btn0),
        .x1       (x1),
        .y1       (y1),
        .btn1     (btn1),
        .frame_vld(frame_vld),
        .err      (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         slot;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } exp_t;

    exp_t        sbq[$];
    logic [39:0] fq[$];
    int          served[$];
    int          nframes = 0;
    int          nerr0 = 0;
    int          nerr1 = 0;
    bit          eng_dead = 1'b0;
    int          bidx = 0;

    // byte engine: answers getByte after 2 cycles, stays busy 3 cycles
    initial begin : engine
        logic [39:0] cur;
        logic [7:0]  exp_ds;
        int          slot;
        exp_t        e;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || cs_n == 2'b11) bidx = 0;
            if (rst_n && getByte && !BUSY && !eng_dead) begin
                slot = cs_n[0] ? 1 : 0;
                if (bidx == 0) begin
                    if (fq.size() > 0) cur = fq.pop_front();
                    else for (int k = 0; k < 5; k++) cur = {cur[31:0], 8'($urandom)};
                end
                exp_ds = (bidx == 0) ? {6'b100000, (slot == 1) ? led1 : led0} : 8'h00;
                check("data_send", Data_send, exp_ds);
                repeat (2) @(posedge clk);
                #1;
                if (rst_n) check("getbyte_hold", getByte, 1);
                BUSY = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                Data_rx = cur[39-8*bidx -: 8];
                BUSY = 1'b0;
                bidx++;
                if (bidx == 5) begin
                    e.slot = slot;
                    e.x    = {cur[25:24], cur[39:32]};
                    e.y    = {cur[9:8], cur[23:16]};
                    e.btn  = cur[2:0];
                    sbq.push_back(e);
                    bidx = 0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t       e;
        int         hi_cnt;
        bit         had_low;
        logic [1:0] cs_prev;
        hi_cnt = 0;
        had_low = 1'b0;
        cs_prev = 2'b11;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int s = 0; s < 2; s++) begin
                    if (frame_vld[s]) begin
                        if (sbq.size() == 0) begin
                            check("sb_underflow", 1, 0);
                        end else begin
                            e = sbq.pop_front();
                            check("vld_slot", s, e.slot);
                            check("pos_x", (s == 1) ? x1 : x0, e.x);
                            check("pos_y", (s == 1) ? y1 : y0, e.y);
                            check("pos_btn", (s == 1) ? btn1 : btn0, e.btn);
                        end
                        served.push_back(s);
                        nframes++;
                    end
                end
                if (err[0]) nerr0++;
                if (err[1]) nerr1++;
                if (|err) check("err_cs_high", cs_n, 2'b11);
                if (cs_n == 2'b11) begin
                    hi_cnt++;
                end else if (cs_prev == 2'b11) begin
                    check("cs_not_both", cs_n == 2'b00, 0);
                    if (had_low) check("cs_gap", hi_cnt >= SETUP, 1);
                    had_low = 1'b1;
                    hi_cnt  = 0;
                end
                cs_prev = cs_n;
            end else begin
                had_low = 1'b0;
                hi_cnt  = 0;
                cs_prev = 2'b11;
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int max_cyc);
        int c = 0;
        while (nframes < target && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check("frames_reached", nframes >= target, 1);
    endtask

    task automatic pulse_req(input logic [1:0] v);
        @(negedge clk);
        req = v;
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
    endtask

    initial begin : main
        int  n0, e0, c;
        logic [9:0] px, py;
        logic [2:0] pb;
        bit  found;

        idle_cycles(3);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_getbyte", getByte, 0);
        check("rst_data_send", Data_send, 0);
        check("rst_x0", x0, 0);
        check("rst_y1", y1, 0);
        check("rst_btn0", btn0, 0);
        check("rst_frame_vld", frame_vld, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // auto poll of slot 0 with a known frame
        fq.push_back(40'h34_02_78_01_05);
        en = 2'b01;
        wait_frames(1, 400);
        en = 2'b00;
        check("p1_x0", x0, 10'h234);
        check("p1_y0", y0, 10'h178);
        check("p1_btn0", btn0, 3'b101);
        check("p1_x1", x1, 0);
        check("p1_y1", y1, 0);
        check("p1_btn1", btn1, 0);
        idle_cycles(300);

        // simultaneous requests straight out of reset
        do_reset();
        served.delete();
        n0 = nframes;
        pulse_req(2'b11);
        wait_frames(n0 + 2, 600);
        check("rr_count", served.size(), 2);
        if (served.size() >= 2) begin
            check("rr_first", served[0], 0);
            check("rr_second", served[1], 1);
        end
        idle_cycles(50);

        // dead engine: timeout abort then normal recovery
        px = x0; py = y0; pb = btn0;
        e0 = nerr0;
        eng_dead = 1'b1;
        pulse_req(2'b01);
        c = 0;
        while (nerr0 == e0 && c < 4 * TIMEOUT) begin
            @(negedge clk);
            c++;
        end
        check("err0_pulse", nerr0, e0 + 1);
        check("err1_none", nerr1, 0);
        check("to_keep_x0", x0, px);
        check("to_keep_y0", y0, py);
        check("to_keep_btn0", btn0, pb);
        check("to_getbyte", getByte, 0);
        eng_dead = 1'b0;
        served.delete();
        n0 = nframes;
        pulse_req(2'b01);
        wait_frames(n0 + 1, 400);
        if (served.size() > 0) check("to_recover_slot", served[0], 0);
        idle_cycles(50);

        // reset while the third byte is being requested
        en = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (bidx == 2 && getByte) found = 1'b1;
        end
        check("rst_mid_found", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", cs_n, 2'b11);
        check("rst_mid_getbyte", getByte, 0);
        idle_cycles(3);
        rst_n = 1'b1;
        check("rst_mid_x0", x0, 0);
        check("rst_mid_y0", y0, 0);
        check("rst_mid_btn0", btn0, 0);
        served.delete();
        n0 = nframes;
        wait_frames(n0 + 1, 400);
        if (served.size() > 0) check("rst_mid_slot", served[0], 0);
        en = 2'b00;
        idle_cycles(300);

        // continuous traffic on both slots alternates
        served.delete();
        n0 = nframes;
        en = 2'b11;
        wait_frames(n0 + 6, 1500);
        en = 2'b00;
        for (int i = 1; i < 6 && i < served.size(); i++) check("alternate", served[i] != served[i-1], 1);
        idle_cycles(400);

        // requests raised while a transaction is in flight are served once each
        served.delete();
        n0 = nframes;
        pulse_req(2'b01);
        c = 0;
        while (cs_n != 2'b10 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("busy_cs_low", cs_n, 2'b10);
        pulse_req(2'b10);
        idle_cycles(3);
        pulse_req(2'b10);
        pulse_req(2'b01);
        wait_frames(n0 + 3, 800);
        idle_cycles(300);
        check("busy_req_count", nframes - n0, 3);
        if (served.size() >= 3) begin
            check("busy_order0", served[0], 0);
            check("busy_order1", served[1], 1);
            check("busy_order2", served[2], 0);
        end
        check("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/joy_poll_sched.md
Name: joy_poll_sched

Overview:
Scheduler/arbiter that shares one SPI mode-0 byte engine between two joystick slots (player 0, player 1), each with its own chip select. It polls enabled slots periodically or on host request, and runs each 5-byte transaction. It decodes frames into X/Y/button outputs with per-slot valid pulses. It sits between the game logic and the SPI byte engine, replacing per-player SPI controllers.

Parameters:
POLL_DIV, 100000, clk cycles between automatic poll rounds (1 ms at 100 MHz); minimum 16
NUM_BYTES, 5, bytes per transaction; fixed by frame format
SETUP, 8, clk cycles from CS low to first byte request, and CS-high gap after a transaction
GAP, 4, idle clk cycles between bytes with CS held low
TIMEOUT, 4095, max clk cycles waiting on any BUSY edge

Ports:
clk  in  1  system clock; all flops on rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  2  per-slot auto-poll enable
req  in  2  per-slot one-cycle immediate poll request
led0  in  2  LED command for slot 0
led1  in  2  LED command for slot 1
BUSY  in  1  byte engine busy
Data_rx  in  8  last received byte; valid when BUSY falls
getByte  out  1  byte transfer request to engine
Data_send  out  8  byte to transmit
cs_n  out  2  active-low chip selects; at most one low
x0, y0  out  10  slot 0 position
btn0  out  3  slot 0 buttons
x1, y1  out  10  slot 1 position
btn1  out  3  slot 1 buttons
frame_vld  out  2  one-cycle pulse per slot on output update
err  out  2  one-cycle pulse per slot on timeout abort

Behaviour:
- Reset: cs_n=2'b11, getByte=0, Data_send=0, all x/y/btn=0, frame_vld=0, err=0, pending=0, rr pointer=1 (slot 0 wins first), poll counter=0, state IDLE.
- Poll counter counts 0..POLL_DIV-1 and wraps. On wrap, tick sets pending[i] |= en[i]. req[i] sets pending[i] in any state. Setting an already-set bit has no further effect.
- Arbitration (IDLE only): if any pending bit is set, grant round-robin, skipping the last-served slot when both are set. Clear the granted pending bit and set rr pointer to the grant. One cycle after grant, cs_n[grant]=0.
- States: IDLE -> SETUP -> REQ -> XFER -> (GAP -> REQ)* -> DONE -> HOLD -> IDLE; ERR from REQ or XFER.
- SETUP: count SETUP cycles, then go to REQ with byte_cnt=0.
- REQ: getByte=1. Data_send = {6'b100000, led[grant]} for byte 0, and 8'h00 otherwise. The LED value is sampled on entering REQ. Hold getByte until BUSY=1, then deassert and go to XFER.
- XFER: wait for BUSY=0. Shift Data_rx into a 40-bit frame register, MSB-first by arrival, and increment byte_cnt. Go to DONE if byte_cnt reaches NUM_BYTES, else to GAP.
- GAP: hold CS low for GAP cycles, then go to REQ.
- DONE (1 cycle): cs_n=2'b11. Decode the frame, with b0..b4 in arrival order: x = {b1[1:0], b0}, y = {b3[1:0], b2}, btn = b4[2:0]. Update only the granted slot's outputs and pulse frame_vld[grant].
- HOLD: cs_n high for SETUP cycles, then go to IDLE. This guarantees minimum CS-high time between slots.
- Timeout: a watchdog resets on each state entry. If it reaches TIMEOUT in REQ or XFER, go to ERR.
- ERR (1 cycle): cs_n=2'b11, getByte=0, pulse err[grant], leave slot outputs unchanged, then go to HOLD.
- Simultaneous tick and req for the same slot set a single pending bit. A tick during a transaction only sets pending; it never preempts.
- en deasserted mid-transaction: the current transaction completes.
- Reset mid-transaction: cs_n goes high immediately (asynchronously); frame data is discarded.
- The poll counter runs in all states.

Decomposition:
- Package joy_pkg: state enum, JSTK_LED_CMD = 6'b100000, FRAME_W = 40, slot index type.
- One sub-module, poll_tick_gen: POLL_DIV counter that outputs a one-cycle tick.

Test Plan:
- en=01, engine model returns bytes 34,02,78,01,05 -> cs_n[0] low for 5 bytes, then x0=0x234, y0=0x178, btn0=3'b101, frame_vld=01; slot 1 untouched.
- led0=2'b11 -> first Data_send=8'h83, remaining four 8'h00; getByte stays high until BUSY rises.
- req=11 in the same cycle from reset -> slot 0 served, then slot 1. cs_n never 00; CS-high gap of at least SETUP cycles between slots.
- Engine never raises BUSY -> after TIMEOUT cycles err[grant] pulses, cs_n=11, outputs keep their previous values, next poll proceeds normally.
- rst_n low during byte 3 -> cs_n=11 and getByte=0 without waiting for a clock edge. After release, outputs are zero and the first tick triggers a fresh 5-byte transaction.
- POLL_DIV=16, en=11, continuous traffic -> slots alternate 0,1,0,1; req pulses while busy are served once each.
